// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads one 32-bit word per instruction from a
// stallable memory bus, presents it byte-reversed to the decoder, and then
// waits for the decoder to retire it before moving the PC forward.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_address,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_done,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        active,
  output logic        fault
);

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] next_pc;
  logic        target_zero;
  logic        target_misaligned;

  // Memory delivers little-endian words; the decoder expects big-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    byte_swap = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign pc_plus4          = pc + 32'd4;
  assign mem_address       = pc;
  assign next_pc           = pc_load ? pc_target : pc_plus4;
  assign target_zero       = (next_pc == 32'h0000_0000);
  assign target_misaligned = (next_pc[1:0] != 2'b00);

  // State, PC, instruction and fault registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      instr <= 32'h0000_0000;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      if (state == FETCH && !mem_waitrequest) begin
        instr <= byte_swap(mem_readdata);
      end
      if (state == HOLD && instr_done) begin
        // A misaligned target halts with the faulting PC left in place so the
        // offending instruction can still be identified.
        if (target_misaligned) begin
          fault <= 1'b1;
        end else begin
          pc <= next_pc;
        end
      end
    end
  end

  // Next-state and bus/decoder handshake outputs.
  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (!mem_waitrequest) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_done) begin
          if (target_zero || target_misaligned) begin
            state_next = HALTED;
          end else begin
            state_next = FETCH;
          end
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
    // While reset is held the bus and decoder see an idle but live unit.
    if (!rst_n) begin
      mem_read    = 1'b0;
      instr_valid = 1'b0;
    end
    active = !rst_n || (state != HALTED);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations,
// then randomized bus stalls, retirements, jumps and resets, all compared
// every cycle against a behavioural model of the fetch unit.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        active;
  logic        fault;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_done      (instr_done),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .active          (active),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_have: an instruction word is being presented to the decoder.
  bit          m_ready = 1'b0;
  bit          m_halted;
  bit          m_have;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_fault;

  function automatic logic [31:0] to_big_endian(input logic [31:0] d);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = d[8*(3-b) +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    logic [31:0] np;
    if (!rst_n) begin
      m_ready  = 1'b1;
      m_halted = 1'b0;
      m_have   = 1'b0;
      m_pc     = 32'hBFC0_0000;
      m_instr  = 32'h0;
      m_fault  = 1'b0;
    end else if (m_ready && !m_halted) begin
      if (!m_have) begin
        if (!mem_waitrequest) begin
          m_instr = to_big_endian(mem_readdata);
          m_have  = 1'b1;
        end
      end else if (instr_done) begin
        np = pc_load ? pc_target : m_pc + 32'd4;
        if (np % 4 != 0) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else begin
          m_pc   = np;
          m_have = 1'b0;
          if (np == 0) m_halted = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("mem_read",    {31'b0, mem_read},    {31'b0, rst_n && !m_halted && !m_have});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, rst_n && !m_halted && m_have});
      chk("active",      {31'b0, active},      {31'b0, !rst_n || !m_halted});
      chk("fault",       {31'b0, fault},       {31'b0, m_fault});
      chk("pc",          pc,          m_pc);
      chk("mem_address", mem_address, m_pc);
      chk("pc_plus4",    pc_plus4,    m_pc + 32'd4);
      chk("instr",       instr,       m_instr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_waitrequest = 1'b0;
    instr_done      = 1'b0;
    pc_load         = 1'b0;
  endtask

  initial begin
    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    step(2);
    chk("rst mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst active", {31'b0, active}, 32'd1);
    chk("rst pc", pc, 32'hBFC0_0000);
    chk("rst instr", instr, 32'h0);

    // Sequential fetch, zero wait states
    mem_readdata = 32'h0100_0000;
    rst_n = 1'b1;
    #1;
    chk("first read", {31'b0, mem_read}, 32'd1);
    chk("first addr", mem_address, 32'hBFC0_0000);
    step(1);
    chk("seq instr", instr, 32'h0000_0001);
    chk("seq valid", {31'b0, instr_valid}, 32'd1);
    chk("seq pc", pc, 32'hBFC0_0000);
    chk("seq no read", {31'b0, mem_read}, 32'd0);
    instr_done = 1'b1;
    step(1);
    instr_done = 1'b0;
    chk("seq next addr", mem_address, 32'hBFC0_0004);

    // Three wait states
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall read", {31'b0, mem_read}, 32'd1);
      chk("stall addr", mem_address, 32'hBFC0_0004);
      chk("stall instr", instr, 32'h0000_0001);
      step(1);
    end
    chk("stall last read", {31'b0, mem_read}, 32'd1);
    mem_waitrequest = 1'b0;
    mem_readdata = 32'h7856_3412;
    step(1);
    chk("stall valid", {31'b0, instr_valid}, 32'd1);
    chk("stall swap", instr, 32'h1234_5678);

    // Jump
    instr_done = 1'b1; pc_load = 1'b1; pc_target = 32'hBFC0_0100;
    step(1);
    idle_inputs();
    chk("jump addr", mem_address, 32'hBFC0_0100);
    chk("jump plus4", pc_plus4, 32'hBFC0_0104);

    // Stray handshake during FETCH
    mem_waitrequest = 1'b1; instr_done = 1'b1; pc_load = 1'b1; pc_target = 32'h0;
    step(1);
    chk("stray pc", pc, 32'hBFC0_0100);
    chk("stray read", {31'b0, mem_read}, 32'd1);
    mem_waitrequest = 1'b0;
    step(1);
    idle_inputs();
    chk("stray valid", {31'b0, instr_valid}, 32'd1);
    chk("stray pc2", pc, 32'hBFC0_0100);

    // Halt on zero target
    instr_done = 1'b1; pc_load = 1'b1; pc_target = 32'h0;
    step(1);
    idle_inputs();
    chk("halt active", {31'b0, active}, 32'd0);
    chk("halt fault", {31'b0, fault}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("halt no read", {31'b0, mem_read}, 32'd0);
      step(1);
    end

    // Halt on misaligned target
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    instr_done = 1'b1; pc_load = 1'b1; pc_target = 32'hBFC0_0102;
    step(1);
    idle_inputs();
    chk("mis active", {31'b0, active}, 32'd0);
    chk("mis fault", {31'b0, fault}, 32'd1);
    chk("mis pc", pc, 32'hBFC0_0000);

    // Reset in the middle of a stalled read at 0xBFC00008
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    instr_done = 1'b1;
    step(1);
    instr_done = 1'b0;
    step(1);
    instr_done = 1'b1;
    step(1);
    instr_done = 1'b0;
    mem_waitrequest = 1'b1;
    step(1);
    chk("mid pc", pc, 32'hBFC0_0008);
    chk("mid read", {31'b0, mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst read", {31'b0, mem_read}, 32'd0);
    step(1);
    rst_n = 1'b1;
    #1;
    chk("mid restart addr", mem_address, 32'hBFC0_0000);
    chk("mid restart instr", instr, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      mem_waitrequest = ($urandom % 3) == 0;
      mem_readdata    = $urandom;
      instr_done      = ($urandom % 3) == 0;
      pc_load         = ($urandom % 4) == 0;
      case ($urandom % 32)
        0:       pc_target = 32'h0;
        1, 2:    pc_target = 32'hBFC0_0000 + ($urandom % 256) * 4 + 1 + ($urandom % 3);
        3:       pc_target = 32'hFFFF_FFFC;
        default: pc_target = 32'hBFC0_0000 + ($urandom % 256) * 4;
      endcase
      if (m_halted) rst_n = !(($urandom % 6) == 0);
      else          rst_n = !(($urandom % 150) == 0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
